// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 status checker.
package connect4_pkg;

  localparam int BOARD_W    = 16;
  localparam int NUM_LINES  = 10;
  localparam int LINE_IDX_W = 4;

  localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(NUM_LINES - 1);

  typedef enum logic [1:0] {
    PLAYING = 2'b00,
    P1_WIN  = 2'b01,
    P2_WIN  = 2'b10,
    DRAW    = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SCAN   = 2'b01,
    DONE   = 2'b10,
    UNUSED = 2'b11
  } state_e;

  // Winner of one line, or PLAYING if the line is not a complete single-owner line.
  function automatic status_e line_result(
    input logic [BOARD_W-1:0] board,
    input logic [BOARD_W-1:0] owner,
    input logic [BOARD_W-1:0] mask
  );
    status_e res;
    res = PLAYING;
    if (mask != '0 && (board & mask) == mask) begin
      if ((owner & mask) == mask)
        res = P2_WIN;
      else if ((owner & mask) == '0)
        res = P1_WIN;
    end
    return res;
  endfunction

endpackage

// File: rtl/line_mask_lut.sv
// Maps a scan line index to its 4-cell board mask; unused indices give an empty mask.
module line_mask_lut
  import connect4_pkg::*;
(
  input  logic [LINE_IDX_W-1:0] line_idx,
  output logic [BOARD_W-1:0]    cell_mask
);

  always_comb begin
    cell_mask = '0;
    case (line_idx)
      4'd0:    cell_mask = 16'h000F;
      4'd1:    cell_mask = 16'h00F0;
      4'd2:    cell_mask = 16'h0F00;
      4'd3:    cell_mask = 16'hF000;
      4'd4:    cell_mask = 16'h1111;
      4'd5:    cell_mask = 16'h2222;
      4'd6:    cell_mask = 16'h4444;
      4'd7:    cell_mask = 16'h8888;
      4'd8:    cell_mask = 16'h8421;
      4'd9:    cell_mask = 16'h1248;
      default: cell_mask = '0;
    endcase
  end

endmodule

// File: rtl/game_status_checker.sv
// Scans a snapshotted 4x4 board one line per cycle and reports a sticky game status.
// Optional draw detection on a full board is enabled by defining C4_DRAW_DETECT_EN.
module game_status_checker
  import connect4_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [BOARD_W-1:0] in_gameboard,
  input  logic [BOARD_W-1:0] in_players_cells,
  input  logic               in_move_done,
  output logic [1:0]         out_game_status,
  output logic               out_status_valid,
  output logic               busy,
  output logic [1:0]         current_state
);

  state_e                state;
  logic [BOARD_W-1:0]    snap_board;
  logic [BOARD_W-1:0]    snap_owner;
  logic [LINE_IDX_W-1:0] line_cnt;
  logic                  pending;
  logic                  win_found;
  status_e               win_status;
  logic [BOARD_W-1:0]    line_mask;
  status_e               line_res;
  status_e               scan_status;

  line_mask_lut u_line_mask_lut (
    .line_idx  (line_cnt),
    .cell_mask (line_mask)
  );

  assign line_res      = line_result(snap_board, snap_owner, line_mask);
  assign current_state = state;

  always_comb begin
    scan_status = win_status;
`ifdef C4_DRAW_DETECT_EN
    if (!win_found && snap_board == '1)
      scan_status = DRAW;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      snap_board       <= '0;
      snap_owner       <= '0;
      line_cnt         <= '0;
      pending          <= 1'b0;
      win_found        <= 1'b0;
      win_status       <= PLAYING;
      out_game_status  <= PLAYING;
      out_status_valid <= 1'b0;
      busy             <= 1'b0;
    end else begin
      out_status_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A deferred strobe restarts here, so its snapshot is the board as it is now.
          if (in_move_done || pending) begin
            snap_board <= in_gameboard;
            snap_owner <= in_players_cells;
            line_cnt   <= '0;
            pending    <= 1'b0;
            win_found  <= 1'b0;
            win_status <= PLAYING;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (in_move_done)
            pending <= 1'b1;
          if (line_res != PLAYING && !win_found) begin
            win_found  <= 1'b1;
            win_status <= line_res;
          end
          if (line_cnt == LAST_LINE)
            state <= DONE;
          else
            line_cnt <= line_cnt + 1'b1;
        end
        DONE: begin
          if (in_move_done)
            pending <= 1'b1;
          // Any decided result is final for the game.
          if (out_game_status == PLAYING)
            out_game_status <= scan_status;
          out_status_valid <= 1'b1;
          busy             <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/game_status_checker.md
GAME_STATUS_CHECKER -- requirements
Module: game_status_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_gameboard, input, 16 bits: occupancy, 1 = cell filled; cell index = row*4+col, row 0 = bottom.
REQ-004 SHALL have port in_players_cells, input, 16 bits: owner per cell, 1 = player 2, 0 = player 1; meaningful only where in_gameboard = 1.
REQ-005 SHALL have port in_move_done, input, 1 bit: one-cycle strobe meaning the board inputs now hold a new stable position.
REQ-006 SHALL have port out_game_status, output, 2 bits: 00 playing, 01 P1 wins, 10 P2 wins, 11 draw; it feeds the column-select FSM's in_game_status.
REQ-007 SHALL have port out_status_valid, output, 1 bit: one-cycle pulse when out_game_status has been updated.
REQ-008 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-009 SHALL have port current_state, output, 2 bits: the FSM state encoding, for debug.

Function
REQ-010 SHALL implement states IDLE=00, SCAN=01 and DONE=10; 11 is unused and SHALL return to IDLE.
REQ-011 In IDLE, in_move_done=1 SHALL snapshot both board inputs into internal registers, clear the line counter, and go to SCAN.
REQ-012 SCAN SHALL test one line per cycle in a fixed order of 10 lines.
  - lines 0-3: rows 0-3
  - lines 4-7: columns 0-3
  - line 8: cells {0,5,10,15}
  - line 9: cells {3,6,9,12}
REQ-013 A line SHALL count as a win for player p when all 4 of its cells are occupied and all 4 are owned by p.
REQ-014 The first winning line in scan order SHALL be recorded; later winning lines in the same scan SHALL be ignored.
REQ-015 After line 9, SCAN SHALL go to DONE; the scan SHALL always take exactly 10 cycles, with no early exit.
REQ-016 DONE SHALL last one cycle, update out_game_status, pulse out_status_valid, then go to IDLE.
  - Latency: strobe sampled at edge N, out_status_valid high in cycle N+11.
REQ-017 busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-018 A strobe arriving in SCAN or DONE SHALL set a pending flag, and the block SHALL start a new scan from IDLE on the next cycle.
  - Multiple strobes SHALL collapse into one pending scan.
  - The new snapshot SHALL be taken when that scan starts.
REQ-019 Win results SHALL be sticky: once the status is 01 or 10, later scans SHALL keep that value, while out_status_valid still pulses.
REQ-020 When a scan finds no win, the status SHALL be 00, unless the draw condition of REQ-025 applies.

Reset
REQ-021 reset=1 at any edge SHALL set the following, including in the middle of a scan:
  - state IDLE
  - out_game_status 00
  - out_status_valid 0
  - busy 0
  - pending 0
  - line counter 0
  - snapshots 0
REQ-022 A strobe in the same cycle as reset SHALL be ignored.
REQ-023 The first strobe accepted after reset SHALL behave exactly as in REQ-011.

Configuration
REQ-024 The feature SHALL be controlled by the macro C4_DRAW_DETECT_EN.
REQ-025 With C4_DRAW_DETECT_EN defined, a scan with no win and snapshot board = 16'hFFFF SHALL yield status 11.
  - Status 11 SHALL be sticky like a win.
REQ-026 Without C4_DRAW_DETECT_EN, status 11 SHALL never be produced; a full board with no win SHALL yield 00.

Structure
REQ-027 Package connect4_pkg SHALL hold the following:
  - status codes (PLAYING, P1_WIN, P2_WIN, DRAW)
  - state encodings
  - NUM_LINES=10
  - board width 16
REQ-028 Sub-module line_mask_lut SHALL map a 4-bit line index to a 16-bit cell mask (combinational); out-of-range indices SHALL map to 0.
REQ-029 game_status_checker SHALL contain the FSM, snapshots, counter, pending flag and win recording.

Verification
REQ-030 Bench SHALL check: board 16'h000F, owners 16'h0000, strobe -> status 01 with valid pulse 11 cycles after strobe; busy high for 10+1 cycles.
REQ-031 Bench SHALL check: board 16'h2222, owners 16'h2222, strobe -> status 10.
REQ-032 Bench SHALL check: board 16'hFFFF, owners 16'h3C3C, strobe -> status 11 with C4_DRAW_DETECT_EN, 00 without.
REQ-033 Bench SHALL check: win on 16'h8421 (P1), then strobe with board 16'h0000 -> status stays 01, valid still pulses.
REQ-034 Bench SHALL check: strobe, then change board to 16'h1111 / owners 16'h0000 and strobe again at scan cycle 5 -> first result 00, then a second scan yields 01 at valid pulse 2.
REQ-035 Bench SHALL check: reset asserted at scan cycle 4 -> next edge state IDLE, busy 0, status 00, no valid pulse.
